// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Hazard, redirect and fetch-control bundle between the pipeline
//               and the PC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
    parameter int BIT_SIZE = 18
);
    logic                imem_ready;
    logic                ex_memread;
    logic [4:0]          ex_rt;
    logic [4:0]          id_rs;
    logic [4:0]          id_rt;
    logic                branch_taken;
    logic [BIT_SIZE-1:0] branch_target;
    logic                jump;
    logic [BIT_SIZE-1:0] jump_target;
    logic                halt;
    logic [BIT_SIZE-1:0] pc;
    logic                if_id_write;
    logic                if_id_flush;
    logic                id_ex_flush;
    logic [1:0]          state;
    logic [15:0]         stall_cycles;

    // Pipeline side: drives hazard/redirect information, consumes fetch control.
    modport master (
        output imem_ready, ex_memread, ex_rt, id_rs, id_rt,
               branch_taken, branch_target, jump, jump_target, halt,
        input  pc, if_id_write, if_id_flush, id_ex_flush, state, stall_cycles
    );

    modport slave (
        input  imem_ready, ex_memread, ex_rt, id_rs, id_rt,
               branch_taken, branch_target, jump, jump_target, halt,
        output pc, if_id_write, if_id_flush, id_ex_flush, state, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch PC sequencer with load-use stall, branch/jump redirect,
//               instruction-memory wait handling and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int                  BIT_SIZE = 18,
    parameter logic [BIT_SIZE-1:0] RESET_PC = '0
) (
    input  wire logic    clk,
    input  wire logic    rst,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [BIT_SIZE-1:0] c_PC_STEP   = BIT_SIZE'(4);
    localparam logic [15:0]         c_STALL_MAX = 16'hFFFF;

    state_t              r_state;
    logic [BIT_SIZE-1:0] r_pc;
    logic                r_pend_valid;
    logic [BIT_SIZE-1:0] r_pend_pc;
    logic [15:0]         r_stall;

    state_t              w_next_state;
    logic [BIT_SIZE-1:0] w_next_pc;
    logic [BIT_SIZE-1:0] w_pc_inc;
    logic                w_next_pend_valid;
    logic [BIT_SIZE-1:0] w_next_pend_pc;
    logic                w_hold;
    logic                w_luh;
    logic                w_if_id_write;
    logic                w_if_id_flush;
    logic                w_id_ex_flush;

    assign w_luh = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                   ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));

    assign w_pc_inc = r_pc + c_PC_STEP;

    always_comb begin
        w_next_state      = r_state;
        w_next_pc         = r_pc;
        w_next_pend_valid = r_pend_valid;
        w_next_pend_pc    = r_pend_pc;
        w_hold            = 1'b0;
        w_if_id_write     = 1'b0;
        w_if_id_flush     = 1'b0;
        w_id_ex_flush     = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (bus.halt) begin
                    w_hold        = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_next_state  = ST_HALTED;
                end else if (bus.branch_taken) begin
                    w_next_pc     = bus.branch_target;
                    w_if_id_write = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (bus.jump) begin
                    w_next_pc     = bus.jump_target;
                    w_if_id_write = 1'b1;
                    w_if_id_flush = 1'b1;
                end else if (w_luh) begin
                    w_hold        = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (!bus.imem_ready) begin
                    w_hold        = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_next_state  = ST_WAIT;
                end else begin
                    w_next_pc     = w_pc_inc;
                    w_if_id_write = 1'b1;
                end
            end

            ST_WAIT: begin
                if (bus.halt) begin
                    w_hold            = 1'b1;
                    w_if_id_flush     = 1'b1;
                    w_id_ex_flush     = 1'b1;
                    w_next_pend_valid = 1'b0;
                    w_next_state      = ST_HALTED;
                end else if (!bus.imem_ready) begin
                    w_hold        = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = bus.branch_taken;
                    // A resolved branch is older than any jump and always wins the slot.
                    if (bus.branch_taken) begin
                        w_next_pend_valid = 1'b1;
                        w_next_pend_pc    = bus.branch_target;
                    end else if (bus.jump && !r_pend_valid) begin
                        w_next_pend_valid = 1'b1;
                        w_next_pend_pc    = bus.jump_target;
                    end
                end else begin
                    w_next_state      = ST_RUN;
                    w_next_pend_valid = 1'b0;
                    if (bus.branch_taken) begin
                        w_next_pc     = bus.branch_target;
                        w_if_id_write = 1'b1;
                        w_if_id_flush = 1'b1;
                        w_id_ex_flush = 1'b1;
                    end else if (r_pend_valid) begin
                        w_next_pc     = r_pend_pc;
                        w_if_id_write = 1'b1;
                        w_if_id_flush = 1'b1;
                    end else if (bus.jump) begin
                        w_next_pc     = bus.jump_target;
                        w_if_id_write = 1'b1;
                        w_if_id_flush = 1'b1;
                    end else if (w_luh) begin
                        w_hold        = 1'b1;
                        w_id_ex_flush = 1'b1;
                    end else begin
                        w_next_pc     = w_pc_inc;
                        w_if_id_write = 1'b1;
                    end
                end
            end

            ST_HALTED: begin
                w_hold        = 1'b1;
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end

            default: begin
                w_hold        = 1'b1;
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
                w_next_state  = ST_RUN;
            end
        endcase

        // Keep the pipeline quiescent for as long as reset is asserted.
        if (rst) begin
            w_if_id_write = 1'b0;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= RESET_PC;
            r_stall      <= 16'd0;
        end else begin
            r_state      <= w_next_state;
            r_pc         <= w_next_pc;
            r_pend_valid <= w_next_pend_valid;
            r_pend_pc    <= w_next_pend_pc;
            if (w_hold && (r_stall != c_STALL_MAX)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    assign bus.pc           = r_pc;
    assign bus.state        = r_state;
    assign bus.stall_cycles = r_stall;
    assign bus.if_id_write  = w_if_id_write;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_flush  = w_id_ex_flush;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int c_BITS = 18;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_sequencer_if #(.BIT_SIZE(c_BITS)) ifc ();

    pc_sequencer #(
        .BIT_SIZE (c_BITS),
        .RESET_PC (18'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ifc.imem_ready    = 1'b1;
        ifc.ex_memread    = 1'b0;
        ifc.ex_rt         = 5'd0;
        ifc.id_rs         = 5'd0;
        ifc.id_rt         = 5'd0;
        ifc.branch_taken  = 1'b0;
        ifc.branch_target = '0;
        ifc.jump          = 1'b0;
        ifc.jump_target   = '0;
        ifc.halt          = 1'b0;
    endtask

    // Advance one rising edge and land 2 time units after it.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic w, input logic f1, input logic f2);
        check({tag, ".if_id_write"}, {31'd0, ifc.if_id_write}, {31'd0, w});
        check({tag, ".if_id_flush"}, {31'd0, ifc.if_id_flush}, {31'd0, f1});
        check({tag, ".id_ex_flush"}, {31'd0, ifc.id_ex_flush}, {31'd0, f2});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        #2;
        check("rst.pc", 32'(ifc.pc), 32'h0);
        check("rst.state", 32'(ifc.state), 32'd0);
        check("rst.stall", 32'(ifc.stall_cycles), 32'd0);
        check_ctl("rst", 1'b0, 1'b1, 1'b1);

        // Sequential fetch after reset release
        repeat (2) @(negedge clk);
        rst = 1'b0;
        settle();
        check_ctl("seq0", 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("seq.pc", 32'(ifc.pc), 32'(4 * i));
        end
        check("seq.stall", 32'(ifc.stall_cycles), 32'd0);
        repeat (4) cyc();
        check("seq.pc20", 32'(ifc.pc), 32'h20);

        // Load-use on rs
        ifc.ex_memread = 1'b1; ifc.ex_rt = 5'd5; ifc.id_rs = 5'd5;
        settle();
        check_ctl("luh_rs", 1'b0, 1'b0, 1'b1);
        cyc();
        check("luh_rs.pc", 32'(ifc.pc), 32'h20);
        check("luh_rs.stall", 32'(ifc.stall_cycles), 32'd1);

        // Register zero never causes a stall
        ifc.ex_rt = 5'd0; ifc.id_rs = 5'd0;
        settle();
        check_ctl("luh_r0", 1'b1, 1'b0, 1'b0);
        cyc();
        check("luh_r0.pc", 32'(ifc.pc), 32'h24);
        check("luh_r0.stall", 32'(ifc.stall_cycles), 32'd1);

        // Load-use on rt
        ifc.ex_rt = 5'd7; ifc.id_rs = 5'd3; ifc.id_rt = 5'd7;
        settle();
        check_ctl("luh_rt", 1'b0, 1'b0, 1'b1);
        cyc();
        check("luh_rt.pc", 32'(ifc.pc), 32'h24);
        check("luh_rt.stall", 32'(ifc.stall_cycles), 32'd2);

        // Branch beats jump and load-use
        idle();
        ifc.branch_taken = 1'b1; ifc.branch_target = 18'h100;
        ifc.jump = 1'b1; ifc.jump_target = 18'h200;
        ifc.ex_memread = 1'b1; ifc.ex_rt = 5'd5; ifc.id_rs = 5'd5;
        settle();
        check_ctl("br_pri", 1'b1, 1'b1, 1'b1);
        cyc();
        check("br_pri.pc", 32'(ifc.pc), 32'h100);
        check("br_pri.stall", 32'(ifc.stall_cycles), 32'd2);

        // Jump alone
        idle();
        ifc.jump = 1'b1; ifc.jump_target = 18'h200;
        settle();
        check_ctl("jmp", 1'b1, 1'b1, 1'b0);
        cyc();
        check("jmp.pc", 32'(ifc.pc), 32'h200);

        // Wrap at the top of the address space
        idle();
        ifc.branch_taken = 1'b1; ifc.branch_target = 18'h3FFF8;
        cyc();
        check("wrap.pc0", 32'(ifc.pc), 32'h3FFF8);
        idle();
        cyc();
        check("wrap.pc1", 32'(ifc.pc), 32'h3FFFC);
        cyc();
        check("wrap.pc2", 32'(ifc.pc), 32'h0);

        // Unaligned target is taken verbatim
        ifc.branch_taken = 1'b1; ifc.branch_target = 18'h103;
        cyc();
        check("unal.pc0", 32'(ifc.pc), 32'h103);
        idle();
        cyc();
        check("unal.pc1", 32'(ifc.pc), 32'h107);

        // Memory wait with pending jump then branch
        ifc.imem_ready = 1'b0;
        settle();
        check_ctl("wait0", 1'b0, 1'b1, 1'b0);
        cyc();
        check("wait0.state", 32'(ifc.state), 32'd1);
        check("wait0.pc", 32'(ifc.pc), 32'h107);
        ifc.jump = 1'b1; ifc.jump_target = 18'h80;
        settle();
        check_ctl("wait1", 1'b0, 1'b1, 1'b0);
        cyc();
        check("wait1.state", 32'(ifc.state), 32'd1);
        ifc.jump = 1'b0;
        ifc.branch_taken = 1'b1; ifc.branch_target = 18'h40;
        settle();
        check_ctl("wait2", 1'b0, 1'b1, 1'b1);
        cyc();
        check("wait2.state", 32'(ifc.state), 32'd1);
        check("wait2.pc", 32'(ifc.pc), 32'h107);
        ifc.branch_taken = 1'b0;
        ifc.imem_ready = 1'b1;
        ifc.jump = 1'b1; ifc.jump_target = 18'h300;
        cyc();
        check("wait3.pc", 32'(ifc.pc), 32'h40);
        check("wait3.state", 32'(ifc.state), 32'd0);
        check("wait3.stall", 32'(ifc.stall_cycles), 32'd5);
        idle();
        cyc();
        check("wait4.pc", 32'(ifc.pc), 32'h44);

        // Halt and asynchronous reset out of HALTED
        ifc.branch_taken = 1'b1; ifc.branch_target = 18'h10;
        cyc();
        idle();
        ifc.halt = 1'b1;
        settle();
        check_ctl("halt", 1'b0, 1'b1, 1'b1);
        cyc();
        check("halt.state", 32'(ifc.state), 32'd2);
        check("halt.pc", 32'(ifc.pc), 32'h10);
        check("halt.stall", 32'(ifc.stall_cycles), 32'd6);
        ifc.halt = 1'b0;
        cyc();
        check_ctl("halted", 1'b0, 1'b1, 1'b1);
        ifc.branch_taken = 1'b1; ifc.branch_target = 18'h500;
        cyc();
        check("halted.pc", 32'(ifc.pc), 32'h10);
        check("halted.state", 32'(ifc.state), 32'd2);
        check("halted.stall", 32'(ifc.stall_cycles), 32'd8);
        idle();
        #1 rst = 1'b1;
        #1;
        check("arst.pc", 32'(ifc.pc), 32'h0);
        check("arst.state", 32'(ifc.state), 32'd0);
        check("arst.stall", 32'(ifc.stall_cycles), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        check("arst.pc1", 32'(ifc.pc), 32'h4);

        // Reset mid-WAIT drops the pending redirect
        ifc.imem_ready = 1'b0;
        cyc();
        check("rwait.state", 32'(ifc.state), 32'd1);
        ifc.branch_taken = 1'b1; ifc.branch_target = 18'h600;
        cyc();
        check("rwait.stall", 32'(ifc.stall_cycles), 32'd2);
        idle();
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        settle();
        check("rwait.pc0", 32'(ifc.pc), 32'h0);
        check("rwait.state0", 32'(ifc.state), 32'd0);
        cyc();
        check("rwait.pc1", 32'(ifc.pc), 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter BIT_SIZE, default 18, PC/address width in bits.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset: asynchronous, active-high.
REQ-005 imem_ready  input  1  instruction memory has valid data for current pc.
REQ-006 ex_memread  input  1  instruction in EX is a load.
REQ-007 ex_rt  input  5  destination register of EX load.
REQ-008 id_rs, id_rt  input  5 each  source registers of ID instruction.
REQ-009 branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-010 branch_target  input  BIT_SIZE  branch destination.
REQ-011 jump  input  1  jump decoded in ID this cycle.
REQ-012 jump_target  input  BIT_SIZE  jump destination.
REQ-013 halt  input  1  halt request.
REQ-014 pc  output  BIT_SIZE  registered fetch address.
REQ-015 if_id_write  output  1  IF/ID register load enable (combinational).
REQ-016 if_id_flush  output  1  insert bubble into IF/ID (combinational).
REQ-017 id_ex_flush  output  1  insert bubble into ID/EX (combinational).
REQ-018 state  output  2  FSM state: 0 RUN, 1 WAIT, 2 HALTED.
REQ-019 stall_cycles  output  16  registered count of cycles pc was held, saturating.

Function
REQ-020 Load-use hazard (luh) SHALL be ex_memread & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
REQ-021 RUN priority, highest first, SHALL be: halt, branch_taken, jump, luh, imem_ready low, sequential.
REQ-022 RUN+halt: pc holds, if_id_write=0, if_id_flush=1, id_ex_flush=1, next state HALTED.
REQ-023 RUN+branch_taken: pc <= branch_target, if_id_flush=1, id_ex_flush=1, if_id_write=1; luh and jump ignored.
REQ-024 RUN+jump (no branch): pc <= jump_target, if_id_flush=1, id_ex_flush=0.
REQ-025 RUN+luh (no redirect): pc holds, if_id_write=0, if_id_flush=0, id_ex_flush=1; exactly one bubble per hazard cycle.
REQ-026 RUN+!imem_ready (no redirect, no luh): pc holds, if_id_flush=1, next state WAIT.
REQ-027 RUN sequential: pc <= pc + 4, modulo 2^BIT_SIZE (0x3FFFC wraps to 0x00000 at 18 bits); if_id_write=1, flushes 0.
REQ-028 WAIT: pc holds, if_id_write=0, if_id_flush=1, id_ex_flush=0 unless branch_taken.
REQ-029 WAIT: branch_taken or jump SHALL be latched into a one-entry pending register (pend_valid, pend_pc); branch overwrites jump, later branch overwrites earlier.
REQ-030 WAIT+branch_taken SHALL also assert id_ex_flush that cycle.
REQ-031 WAIT+imem_ready: if pend_valid, pc <= pend_pc and pend_valid cleared; else pc <= pc + 4; next state RUN; redirect/luh inputs that cycle are handled per REQ-021 with pending target taking precedence over same-cycle jump but not same-cycle branch_taken.
REQ-032 WAIT+halt SHALL go to HALTED, discarding pending redirect.
REQ-033 HALTED: pc holds, if_id_write=0, if_id_flush=1, id_ex_flush=1; exits only via rst.
REQ-034 stall_cycles SHALL increment on every cycle pc is held (luh, WAIT, HALTED, halt entry), saturating at 0xFFFF.
REQ-035 Targets SHALL be used as given; no alignment correction.

Reset
REQ-036 rst high SHALL immediately set pc=RESET_PC, state=RUN, pend_valid=0, stall_cycles=0, regardless of clk.
REQ-037 While rst high, combinational outputs SHALL be if_id_write=0, if_id_flush=1, id_ex_flush=1.
REQ-038 Reset mid-WAIT or mid-HALTED SHALL discard all pending state; first fetch after release is RESET_PC.

Verification
REQ-039 Reset release, imem_ready=1, 4 cycles -> pc 0,4,8,12,16; stall_cycles=0.
REQ-040 pc=0x3FFF8, sequential 2 cycles -> pc 0x3FFFC then 0x00000.
REQ-041 ex_memread=1, ex_rt=5, id_rs=5 for 1 cycle at pc=0x20 -> pc stays 0x20, id_ex_flush=1, if_id_write=0, stall_cycles=1; ex_rt=0 same stimulus -> no stall.
REQ-042 branch_taken=1 target 0x100 with jump=1 target 0x200 and luh true -> pc=0x100, both flushes 1.
REQ-043 imem_ready low 3 cycles, jump to 0x80 in cycle 1, branch to 0x40 in cycle 2, ready returns -> state WAIT for 3 cycles, then pc=0x40, state RUN, stall_cycles=3.
REQ-044 halt pulse at pc=0x10, then rst pulse mid-HALTED -> pc frozen at 0x10, state=2; after async rst pc=RESET_PC, state=0, stall_cycles=0 without a clock edge.
